// File: rtl/fetch_seq_pkg.sv
// rtl/fetch_seq_pkg.sv - Y86 fetch unit constants, icodes and state encodings
package fetch_seq_pkg;

    localparam int DATA_WID     = 64;
    localparam int ADDR_WID     = DATA_WID;
    localparam int VALC_WID     = DATA_WID;
    localparam int INSTR_MAXLEN = 10;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_HALT    = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_seq_if.sv
// rtl/fetch_seq_if.sv - fetch request, byte memory and instruction delivery bundle
interface fetch_seq_if;
    import fetch_seq_pkg::*;

    logic                fetch_go;
    logic [ADDR_WID-1:0] fetch_pc;
    logic                fetch_busy;
    logic                mem_rd;
    logic [ADDR_WID-1:0] mem_addr;
    logic [7:0]          mem_rdata;
    logic                mem_rvalid;
    logic                instr_valid;
    logic                instr_ready;
    logic [3:0]          icode;
    logic [3:0]          ifun;
    logic [3:0]          rA;
    logic [3:0]          rB;
    logic [VALC_WID-1:0] valC;
    logic [ADDR_WID-1:0] pc_out;
    logic                instr_err;
    logic                halted;

    // fetch unit side
    modport master (
        input  fetch_go, fetch_pc, mem_rdata, mem_rvalid, instr_ready,
        output fetch_busy, mem_rd, mem_addr, instr_valid,
               icode, ifun, rA, rB, valC, pc_out, instr_err, halted
    );

    // memory / control / downstream side
    modport slave (
        output fetch_go, fetch_pc, mem_rdata, mem_rvalid, instr_ready,
        input  fetch_busy, mem_rd, mem_addr, instr_valid,
               icode, ifun, rA, rB, valC, pc_out, instr_err, halted
    );

endinterface

// File: rtl/fetch_len_dec.sv
// rtl/fetch_len_dec.sv - instruction length/layout table shared with PC increment
module fetch_len_dec
    import fetch_seq_pkg::*;
(
    input  logic [3:0] icode,
    output logic [3:0] len,
    output logic       has_regs,
    output logic       has_valc,
    output logic [3:0] valc_off,
    output logic       invalid
);

    // Byte layout per icode; unknown codes are treated as 1-byte instructions
    always_comb begin
        len      = 4'd1;
        has_regs = 1'b0;
        has_valc = 1'b0;
        valc_off = 4'd0;
        invalid  = 1'b0;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len = 4'd1;
            end
            I_RRMOV, I_OP, I_PUSH, I_POP: begin
                len      = 4'd2;
                has_regs = 1'b1;
            end
            I_JXX, I_CALL: begin
                len      = 4'd9;
                has_valc = 1'b1;
                valc_off = 4'd1;
            end
            I_IRMOV, I_RMMOV, I_MRMOV: begin
                len      = 4'(INSTR_MAXLEN);
                has_regs = 1'b1;
                has_valc = 1'b1;
                valc_off = 4'd2;
            end
            default: begin
                invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - byte-serial Y86 instruction fetch sequencer
module fetch_seq
    import fetch_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    fetch_seq_if.master bus
);

    fetch_state_t        state, state_nxt;
    logic [ADDR_WID-1:0] addr_q;
    logic [ADDR_WID-1:0] pc_q;
    logic [ADDR_WID-1:0] k;
    logic [3:0]          icode_q, ifun_q, ra_q, rb_q;
    logic [VALC_WID-1:0] valc_q;

    logic       first_byte, byte_take, last_byte;
    logic [3:0] dec_icode, dec_len, dec_valc_off;
    logic       dec_has_regs, dec_has_valc, dec_invalid;
    logic [2:0] valc_idx;

    // Byte index within the instruction; wraps with the address
    assign k          = addr_q - pc_q;
    assign first_byte = (k == '0);
    assign byte_take  = (state == ST_WAIT) && bus.mem_rvalid;

    // On byte 0 the length must come from the incoming byte, not the stale icode
    assign dec_icode  = (state == ST_WAIT && first_byte) ? bus.mem_rdata[7:4] : icode_q;
    assign last_byte  = ((k + ADDR_WID'(1)) == {{(ADDR_WID-4){1'b0}}, dec_len});
    assign valc_idx   = 3'(k[3:0] - dec_valc_off);

    fetch_len_dec u_len_dec (
        .icode    (dec_icode),
        .len      (dec_len),
        .has_regs (dec_has_regs),
        .has_valc (dec_has_valc),
        .valc_off (dec_valc_off),
        .invalid  (dec_invalid)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: one outstanding read per REQ/WAIT pair, HALT is terminal
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (bus.fetch_go) state_nxt = ST_REQ;
            ST_REQ:     state_nxt = ST_WAIT;
            ST_WAIT:    if (bus.mem_rvalid) state_nxt = last_byte ? ST_DELIVER : ST_REQ;
            ST_DELIVER: if (bus.instr_ready) state_nxt = (icode_q == I_HALT) ? ST_HALT : ST_IDLE;
            ST_HALT:    state_nxt = ST_HALT;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Address/PC capture and field assembly from returned bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            pc_q    <= '0;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            valc_q  <= '0;
        end else if (state == ST_IDLE && bus.fetch_go) begin
            addr_q  <= bus.fetch_pc;
            pc_q    <= bus.fetch_pc;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= REG_NONE;
            rb_q    <= REG_NONE;
            valc_q  <= '0;
        end else if (byte_take) begin
            addr_q <= addr_q + ADDR_WID'(1);
            if (first_byte) begin
                icode_q <= bus.mem_rdata[7:4];
                ifun_q  <= bus.mem_rdata[3:0];
            end else if (dec_has_regs && k == ADDR_WID'(1)) begin
                ra_q <= bus.mem_rdata[7:4];
                rb_q <= bus.mem_rdata[3:0];
            end else if (dec_has_valc && k[3:0] >= dec_valc_off) begin
                valc_q[{valc_idx, 3'b000} +: 8] <= bus.mem_rdata;
            end
        end
    end

    assign bus.fetch_busy  = (state != ST_IDLE);
    assign bus.mem_rd      = (state == ST_REQ);
    assign bus.mem_addr    = addr_q;
    assign bus.instr_valid = (state == ST_DELIVER);
    assign bus.instr_err   = (state == ST_DELIVER) && dec_invalid;
    assign bus.halted      = (state == ST_HALT);
    assign bus.icode       = icode_q;
    assign bus.ifun        = ifun_q;
    assign bus.rA          = ra_q;
    assign bus.rB          = rb_q;
    assign bus.valC        = valc_q;
    assign bus.pc_out      = pc_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

    logic clk;
    logic rst_n;

    fetch_seq_if bus ();

    fetch_seq u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  mem [512];
    logic [63:0] addr_log [64];
    logic [63:0] raddr = '0;
    int          mem_lat = 1;
    int          cnt = 0;
    int          rd_cnt = 0;
    int          rd_base = 0;
    int          cyc;

    // Byte memory with programmable latency; not reset so stale responses survive rst_n
    always @(posedge clk) begin
        if (cnt != 0) cnt <= cnt - 1;
        if (bus.mem_rd) begin
            cnt                  <= mem_lat;
            raddr                <= bus.mem_addr;
            addr_log[rd_cnt % 64] <= bus.mem_addr;
            rd_cnt               <= rd_cnt + 1;
        end
    end

    assign bus.mem_rvalid = (cnt == 1);
    assign bus.mem_rdata  = mem[raddr[8:0]];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns cycles from the fetch_go cycle to instr_valid
    task automatic start_fetch(input logic [63:0] pc, input int lat, output int c);
        mem_lat = lat;
        rd_base = rd_cnt;
        bus.fetch_pc = pc;
        bus.fetch_go = 1'b1;
        @(negedge clk);
        bus.fetch_go = 1'b0;
        c = 1;
        while (!bus.instr_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("valid_timeout", {63'd0, bus.instr_valid}, 64'd1);
    endtask

    task automatic deliver(input int hold, input logic [63:0] exp_valc);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", {63'd0, bus.instr_valid}, 64'd1);
            chk("hold_valc", bus.valC, exp_valc);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        bus.instr_ready = 1'b0;
        chk("valid_drop", {63'd0, bus.instr_valid}, 64'd0);
    endtask

    task automatic chk_fields(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                              input logic [3:0] ra, input logic [3:0] rb,
                              input logic [63:0] vc, input logic [63:0] pc);
        chk({tag, "_icode"}, {60'd0, bus.icode}, {60'd0, ic});
        chk({tag, "_ifun"},  {60'd0, bus.ifun},  {60'd0, fn});
        chk({tag, "_rA"},    {60'd0, bus.rA},    {60'd0, ra});
        chk({tag, "_rB"},    {60'd0, bus.rB},    {60'd0, rb});
        chk({tag, "_valC"},  bus.valC, vc);
        chk({tag, "_pc"},    bus.pc_out, pc);
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h000] = 8'h30; mem[9'h001] = 8'hF2; mem[9'h002] = 8'h0A;
        mem[9'h020] = 8'h80; mem[9'h021] = 8'h34; mem[9'h022] = 8'h12;
        mem[9'h040] = 8'hD0;
        mem[9'h100] = 8'h10;
        mem[9'h1FF] = 8'hA0;

        bus.fetch_go    = 1'b0;
        bus.fetch_pc    = '0;
        bus.instr_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset state
        chk("rst_busy",   {63'd0, bus.fetch_busy},  64'd0);
        chk("rst_mem_rd", {63'd0, bus.mem_rd},      64'd0);
        chk("rst_addr",   bus.mem_addr,             64'd0);
        chk("rst_valid",  {63'd0, bus.instr_valid}, 64'd0);
        chk("rst_err",    {63'd0, bus.instr_err},   64'd0);
        chk("rst_halted", {63'd0, bus.halted},      64'd0);
        chk_fields("rst", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);

        // instr_ready with no instruction pending
        bus.instr_ready = 1'b1;
        repeat (2) @(negedge clk);
        bus.instr_ready = 1'b0;
        chk("idle_ready_busy",  {63'd0, bus.fetch_busy},  64'd0);
        chk("idle_ready_valid", {63'd0, bus.instr_valid}, 64'd0);

        // NOP at 0x100, L=1
        start_fetch(64'h100, 1, cyc);
        chk("nop_lat", cyc, 3);
        chk("nop_reads", rd_cnt - rd_base, 1);
        chk("nop_addr", addr_log[rd_base % 64], 64'h100);
        chk("nop_err", {63'd0, bus.instr_err}, 64'd0);
        chk_fields("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h100);
        deliver(0, 64'd0);

        // IRMOV at 0x0, L=1
        start_fetch(64'h0, 1, cyc);
        chk("irmov_lat", cyc, 21);
        chk("irmov_reads", rd_cnt - rd_base, 10);
        chk("irmov_first", addr_log[rd_base % 64], 64'h0);
        chk("irmov_last", addr_log[(rd_base + 9) % 64], 64'h9);
        chk_fields("irmov", 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'h0);
        deliver(0, 64'hA);

        // CALL at 0x20, L=3, downstream stalls 5 cycles
        start_fetch(64'h20, 3, cyc);
        chk("call_lat", cyc, 37);
        chk_fields("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h20);
        deliver(5, 64'h1234);
        chk("call_reads", rd_cnt - rd_base, 9);

        // invalid icode 0xD at 0x40
        start_fetch(64'h40, 1, cyc);
        chk("inv_lat", cyc, 3);
        chk("inv_err", {63'd0, bus.instr_err}, 64'd1);
        chk("inv_reads", rd_cnt - rd_base, 1);
        chk("inv_icode", {60'd0, bus.icode}, 64'hD);
        deliver(0, 64'd0);
        chk("inv_halted", {63'd0, bus.halted}, 64'd0);

        // PUSH spanning the top of the address space, L=2
        start_fetch(64'hFFFF_FFFF_FFFF_FFFF, 2, cyc);
        chk("wrap_lat", cyc, 7);
        chk("wrap_reads", rd_cnt - rd_base, 2);
        chk("wrap_last", addr_log[(rd_base + 1) % 64], 64'h0);
        chk_fields("wrap", 4'hA, 4'h0, 4'h3, 4'h0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        deliver(0, 64'd0);

        // HALT at 0x60
        start_fetch(64'h60, 1, cyc);
        chk("halt_lat", cyc, 3);
        deliver(0, 64'd0);
        chk("halt_halted", {63'd0, bus.halted}, 64'd1);
        chk("halt_busy", {63'd0, bus.fetch_busy}, 64'd1);
        rd_base = rd_cnt;
        for (int i = 0; i < 2; i++) begin
            bus.fetch_pc = 64'h100;
            bus.fetch_go = 1'b1;
            @(negedge clk);
            bus.fetch_go = 1'b0;
            repeat (2) @(negedge clk);
        end
        chk("halt_no_reads", rd_cnt - rd_base, 0);
        chk("halt_sticky", {63'd0, bus.halted}, 64'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("halt_cleared", {63'd0, bus.halted}, 64'd0);

        // reset in the middle of an IRMOV with a response still in flight
        mem_lat = 4;
        rd_base = rd_cnt;
        bus.fetch_pc = 64'h0;
        bus.fetch_go = 1'b1;
        @(negedge clk);
        bus.fetch_go = 1'b0;
        cyc = 0;
        while (rd_cnt - rd_base < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("midrst_reach", rd_cnt - rd_base, 3);
        rst_n = 1'b0;
        #1;
        chk("midrst_busy_async", {63'd0, bus.fetch_busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("midrst_busy", {63'd0, bus.fetch_busy}, 64'd0);
        chk("midrst_reads", rd_cnt - rd_base, 3);
        chk("midrst_addr", bus.mem_addr, 64'd0);
        chk_fields("midrst", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0);

        start_fetch(64'h0, 1, cyc);
        chk("refetch_lat", cyc, 21);
        chk_fields("refetch", 4'h3, 4'h0, 4'hF, 4'h2, 64'hA, 64'h0);
        deliver(0, 64'hA);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
